// File: rtl/rsa_modexp_seq.sv
// -----------------------------------------------------------------------------
// rsa_modexp_seq
// Left-to-right square-and-multiply sequencer for the Montgomery modular
// exponentiation path. Scans a latched exponent MSB-first and issues one
// request per operation to a shared Montgomery multiplier through a
// start/done handshake. Run order: PRE_M, PRE_X, exponent loop (SQR, plus MUL
// for every set bit), POST, then a one-cycle done pulse.
//
// Ports:
//   clk        rising-edge clock
//   rstb       synchronous active-low reset
//   ena        global clock enable; state advances only when high
//   start      begin exponentiation (sampled in IDLE only)
//   abort      cancel current run, return to IDLE (beats start and mul_done)
//   exponent   exponent E, latched on an accepted start
//   mul_done   multiplier completion pulse (sampled in WAIT only)
//   mul_start  multiplier request, one enabled cycle per operation
//   mul_op     opcode: 0 PRE_M, 1 PRE_X, 2 SQR, 3 MUL, 4 POST, 7 idle
//   busy       high from accepted start until done/abort
//   done       one-enabled-cycle pulse when POST completes
//   bit_cnt    exponent bits remaining
// -----------------------------------------------------------------------------
module rsa_modexp_seq #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] exponent,
   input  logic             mul_done,
   output logic             mul_start,
   output logic [2:0]       mul_op,
   output logic             busy,
   output logic             done,
   output logic [CNTW-1:0]  bit_cnt
);

   localparam logic [2:0] OP_PRE_M = 3'd0;
   localparam logic [2:0] OP_PRE_X = 3'd1;
   localparam logic [2:0] OP_SQR   = 3'd2;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_POST  = 3'd4;
   localparam logic [2:0] OP_IDLE  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [WIDTH-1:0] r_e_sh;
   logic [WIDTH-1:0] w_e_sh_nx;
   logic [CNTW-1:0]  r_bit_cnt;
   logic [CNTW-1:0]  w_bit_cnt_nx;
   logic [CNTW-1:0]  w_cnt_dec;
   logic [2:0]       r_op;        // current opcode; doubles as the mul_op output
   logic [2:0]       w_op_nx;
   logic [2:0]       w_op_after_bit;
   logic             r_busy;
   logic             w_busy_nx;
   logic             r_mul_start;
   logic             r_done;

   // Saturating decrement and the op that follows a fully processed exponent bit
   always_comb begin
      if (r_bit_cnt != {CNTW{1'b0}}) begin
         w_cnt_dec = r_bit_cnt - CNTW'(1);
      end else begin
         w_cnt_dec = r_bit_cnt;
      end
      if (w_cnt_dec != {CNTW{1'b0}}) begin
         w_op_after_bit = OP_SQR;
      end else begin
         w_op_after_bit = OP_POST;
      end
   end

   // Next-state and next-register values
   always_comb begin
      w_state_nx   = r_state;
      w_e_sh_nx    = r_e_sh;
      w_bit_cnt_nx = r_bit_cnt;
      w_op_nx      = r_op;
      w_busy_nx    = r_busy;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_e_sh_nx    = exponent;
               w_bit_cnt_nx = CNTW'(WIDTH);
               w_busy_nx    = 1'b1;
               w_op_nx      = OP_PRE_M;
               w_state_nx   = ST_ISSUE;
            end else begin
               w_op_nx      = OP_IDLE;
            end
         end
         ST_ISSUE: begin
            w_state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (mul_done) begin
               w_state_nx = ST_ISSUE;
               case (r_op)
                  OP_PRE_M: w_op_nx = OP_PRE_X;
                  OP_PRE_X: begin
                     if (r_bit_cnt != {CNTW{1'b0}}) begin
                        w_op_nx = OP_SQR;
                     end else begin
                        w_op_nx = OP_POST;
                     end
                  end
                  OP_SQR: begin
                     if (r_e_sh[WIDTH-1]) begin
                        w_op_nx = OP_MUL;
                     end else begin
                        w_e_sh_nx    = {r_e_sh[WIDTH-2:0], 1'b0};
                        w_bit_cnt_nx = w_cnt_dec;
                        w_op_nx      = w_op_after_bit;
                     end
                  end
                  OP_MUL: begin
                     w_e_sh_nx    = {r_e_sh[WIDTH-2:0], 1'b0};
                     w_bit_cnt_nx = w_cnt_dec;
                     w_op_nx      = w_op_after_bit;
                  end
                  OP_POST: begin
                     w_state_nx = ST_DONE;
                     w_busy_nx  = 1'b0;
                     w_op_nx    = OP_IDLE;
                  end
                  default: begin
                     w_state_nx = ST_IDLE;
                     w_busy_nx  = 1'b0;
                     w_op_nx    = OP_IDLE;
                  end
               endcase
            end else begin
               w_state_nx = ST_WAIT;
            end
         end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
            w_op_nx    = OP_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_busy_nx  = 1'b0;
            w_op_nx    = OP_IDLE;
         end
      endcase
      // abort overrides everything above, including start and mul_done
      if (abort) begin
         w_state_nx   = ST_IDLE;
         w_bit_cnt_nx = {CNTW{1'b0}};
         w_busy_nx    = 1'b0;
         w_op_nx      = OP_IDLE;
      end else begin
         w_state_nx   = w_state_nx;
      end
   end

   // State and registered outputs; everything holds while ena is low
   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state     <= ST_IDLE;
         r_e_sh      <= {WIDTH{1'b0}};
         r_bit_cnt   <= {CNTW{1'b0}};
         r_op        <= OP_IDLE;
         r_busy      <= 1'b0;
         r_mul_start <= 1'b0;
         r_done      <= 1'b0;
      end else if (ena) begin
         r_state     <= w_state_nx;
         r_e_sh      <= w_e_sh_nx;
         r_bit_cnt   <= w_bit_cnt_nx;
         r_op        <= w_op_nx;
         r_busy      <= w_busy_nx;
         r_mul_start <= (w_state_nx == ST_ISSUE);
         r_done      <= (w_state_nx == ST_DONE);
      end
   end

   assign mul_start = r_mul_start;
   assign mul_op    = r_op;
   assign busy      = r_busy;
   assign done      = r_done;
   assign bit_cnt   = r_bit_cnt;

endmodule

// File: doc/rsa_modexp_seq.md
Name: rsa_modexp_seq

Overview:
Left-to-right square-and-multiply sequencer for the bit-serial Montgomery modular exponentiation path. It scans a latched exponent MSB-first. For each operation it issues one request to the shared Montgomery multiplier through a start/done handshake, with an opcode that selects the operand routing. It performs domain entry (PRE), the exponent loop and domain exit (POST), then signals completion.

Parameters:
WIDTH, 8, exponent width in bits (>=2)
CNTW, $clog2(WIDTH+1), width of bit counter

Ports:
clk  input  1  rising-edge clock
rstb  input  1  reset, synchronous, active-low
ena  input  1  global clock enable; all state advances only when ena=1
start  input  1  begin exponentiation (sampled in IDLE only)
abort  input  1  cancel current run, return to IDLE
exponent  input  WIDTH  exponent E, latched on accepted start
mul_done  input  1  multiplier completion pulse (one enabled cycle)
mul_start  output  1  multiplier request, high for exactly one enabled cycle per op
mul_op  output  3  opcode: 0 PRE_M (M*R2->Mb), 1 PRE_X (1*R2->X), 2 SQR (X*X->X), 3 MUL (X*Mb->X), 4 POST (X*1->result), 7 idle
busy  output  1  high from accepted start until done/abort
done  output  1  one-enabled-cycle pulse when POST completes
bit_cnt  output  CNTW  exponent bits remaining

Behaviour:
- Reset (rstb=0 at rising clk, regardless of ena): state=IDLE, busy=0, done=0, mul_start=0, mul_op=7, bit_cnt=0, exponent shadow=0.
- ena=0: all registers hold, outputs unchanged (mul_start may stay high; the multiplier shares ena, so the request is consumed on the next enabled edge).
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: done=0. On start=1 & abort=0: latch exponent into e_sh, bit_cnt<=WIDTH, busy<=1, op<=PRE_M, go to ISSUE.
- ISSUE (exactly one enabled cycle): mul_start=1, mul_op=op. Next state is WAIT.
- WAIT: mul_start=0, mul_op is held. mul_done is sampled only here; mul_done in any other state is ignored. On mul_done, select the next op:
  - PRE_M -> PRE_X.
  - PRE_X -> SQR if bit_cnt>0, else POST.
  - SQR -> MUL if e_sh[WIDTH-1]=1. Otherwise shift e_sh left by 1, bit_cnt-=1, then SQR if bit_cnt(new)>0, else POST.
  - MUL -> shift e_sh left, bit_cnt-=1, then SQR if bit_cnt(new)>0, else POST.
  - POST -> DONE.
  - All transitions other than POST->DONE go to ISSUE.
- DONE: done=1 for one enabled cycle, busy<=0, mul_op<=7, then IDLE.
- Op count: 2 + WIDTH + popcount(E) + 1. Enabled cycles from start to done pulse: 1 + sum over ops of (1 + wait_i), where wait_i>=1 is the number of WAIT cycles up to and including mul_done.
- E=0: all SQR, no MUL; POST yields Montgomery 1 -> result 1.
- start while busy: ignored; exponent is not re-latched.
- abort (any state, enabled cycle): next state IDLE, busy=0, mul_start=0, mul_op=7, done=0, bit_cnt=0. abort beats start and mul_done in the same cycle. An in-flight multiplier op is abandoned; a later stray mul_done is ignored in IDLE.
- bit_cnt wraps never: decrement only occurs when bit_cnt>0.
- Reset mid-run: identical to the reset values above.

Test Plan:
- Reset: hold rstb=0 two cycles with start=1 -> busy=0, mul_op=7, mul_start=0, no done.
- WIDTH=4, E=4'b1011, mul_done returned 1 cycle after each mul_start -> mul_op sequence 0,1,2,3,2,2,3,2,3,4; exactly 10 mul_start pulses; done pulses 21 enabled cycles after start; busy falls with done.
- WIDTH=4, E=0 -> sequence 0,1,2,2,2,2,4; no op 3; done asserted once.
- ena toggled 0/1 every other cycle during E=4'b1001 run -> same op sequence as with ena=1; each mul_start visible for exactly one enabled edge.
- Abort in WAIT of the second SQR, with mul_done asserted the same cycle -> IDLE next cycle, busy=0, no further mul_start, no done. A subsequent start with E=4'b0001 runs cleanly: 0,1,2,2,2,2,3,4.
- start pulsed mid-run with a different exponent -> ignored; op sequence and result match the first exponent; stray mul_done in IDLE produces no activity.
